// File: rtl/trap_base_unit_if.sv
// Trap arbiter bus: trap sources, PSR.ET, ControlUnit handshake, WRTBR and TBR readback.
interface trap_base_unit_if #(
  parameter int unsigned N_SRC = 8,
  parameter int unsigned TT_W  = 8
);
  logic [N_SRC-1:0] trap_src;
  logic             ET;
  logic             trap_ack;
  logic             TBR_enable;
  logic [31:0]      TBR_in;
  logic             TBR_Clr;
  logic             trap_req;
  logic [TT_W-1:0]  tt;
  logic [31:0]      TBR_out;
  logic [N_SRC-1:0] pending;
  logic             error_mode;

  // Master side: trap sources plus ControlUnit.
  modport master (
    output trap_src, ET, trap_ack, TBR_enable, TBR_in, TBR_Clr,
    input  trap_req, tt, TBR_out, pending, error_mode
  );

  // Slave side: the trap base unit itself.
  modport slave (
    input  trap_src, ET, trap_ack, TBR_enable, TBR_in, TBR_Clr,
    output trap_req, tt, TBR_out, pending, error_mode
  );
endinterface

// File: rtl/trap_base_unit.sv
// Trap base register (TBR) and fixed-priority trap arbiter. Source 0 is highest priority.
module trap_base_unit #(
  parameter int unsigned      N_SRC    = 8,
  parameter int unsigned      TT_W     = 8,
  parameter logic [TT_W-1:0]  TT_BASE  = TT_W'(8'h01),
  parameter logic [N_SRC-1:0] MASKABLE = N_SRC'(8'hF0)
) (
  input logic               Clk,
  input logic               RESET,
  trap_base_unit_if.slave   bus
);

  localparam int unsigned SelW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  typedef enum logic [1:0] {StIdle, StReq, StError} state_e;

  state_e           state_q;
  logic [SelW-1:0]  sel_q;
  logic [SelW-1:0]  sel_c;
  logic [TT_W-1:0]  tt_q;
  logic             trap_req_q;
  logic             error_mode_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr_mask;
  logic             fatal;
  logic             ack_fire;
  logic [19:0]      tba_q;
  logic [7:0]       tbr_tt_q;

  // WRTBR only uses the TBA field; the low bits are intentionally dropped.
  logic unused_tbr_in_low;
  assign unused_tbr_in_low = ^bus.TBR_in[11:0];

  // Eligibility, fatal detection, priority pick and the ack-driven pending clear.
  always_comb begin
    eligible = pending_q & (bus.ET ? {N_SRC{1'b1}} : ~MASKABLE);
    fatal    = (|(pending_q & ~MASKABLE)) & ~bus.ET;
    sel_c    = '0;
    // Descending scan so the lowest set index wins.
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (eligible[i]) sel_c = SelW'(i);
    end
    ack_fire = (state_q == StReq) & bus.trap_ack;
    clr_mask = '0;
    if (ack_fire) clr_mask[sel_q] = 1'b1;
  end

  // Sticky pending bits; a new request in the same cycle as its clear wins.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      pending_q <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_mask) | bus.trap_src;
    end
  end

  // Arbiter FSM with registered trap_req, tt and error_mode.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      state_q      <= StIdle;
      sel_q        <= '0;
      tt_q         <= '0;
      trap_req_q   <= 1'b0;
      error_mode_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (fatal) begin
            state_q      <= StError;
            error_mode_q <= 1'b1;
          end else if (|eligible) begin
            sel_q      <= sel_c;
            tt_q       <= TT_BASE + TT_W'(sel_c);
            trap_req_q <= 1'b1;
            state_q    <= StReq;
          end
        end
        StReq: begin
          // No preemption: sel/tt stay frozen until the ControlUnit acks.
          if (bus.trap_ack) begin
            trap_req_q <= 1'b0;
            state_q    <= StIdle;
          end
        end
        StError: begin
          error_mode_q <= 1'b1;
          trap_req_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // TBR fields: clear beats WRTBR and the ack tt capture; the latter two may coincide.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      tba_q    <= '0;
      tbr_tt_q <= '0;
    end else if (bus.TBR_Clr) begin
      tba_q    <= '0;
      tbr_tt_q <= '0;
    end else begin
      if (bus.TBR_enable) tba_q <= bus.TBR_in[31:12];
      if (ack_fire) tbr_tt_q <= 8'(tt_q);
    end
  end

  assign bus.trap_req   = trap_req_q;
  assign bus.tt         = tt_q;
  assign bus.TBR_out    = {tba_q, tbr_tt_q, 4'b0000};
  assign bus.pending    = pending_q;
  assign bus.error_mode = error_mode_q;

endmodule

// File: tb/tb_trap_base_unit.sv
// Directed bench for trap_base_unit: stimulus pushes expected tt codes into a scoreboard
// queue, a negedge monitor pops one on every new trap_req and checks tt stays frozen.
module tb_trap_base_unit;

  logic Clk;
  logic RESET;

  trap_base_unit_if #(.N_SRC(8), .TT_W(8)) bus ();

  trap_base_unit dut (
    .Clk   (Clk),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic [7:0] cur_tt;
  logic       prev_req;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Inputs applied after this take effect at the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Scoreboard monitor.
  initial prev_req = 1'b0;
  always @(negedge Clk) begin
    if (!RESET) begin
      if (bus.trap_req && !prev_req) begin
        if (exp_q.size() == 0) begin
          check("unexpected_trap_req", 32'(bus.tt), 32'hFFFF_FFFF);
        end else begin
          cur_tt = exp_q.pop_front();
          check("sb_tt", 32'(bus.tt), 32'(cur_tt));
        end
      end else if (bus.trap_req && prev_req) begin
        check("sb_tt_hold", 32'(bus.tt), 32'(cur_tt));
      end
    end
    prev_req = bus.trap_req;
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    RESET          = 1'b0;
    bus.trap_src   = '0;
    bus.ET         = 1'b0;
    bus.trap_ack   = 1'b0;
    bus.TBR_enable = 1'b0;
    bus.TBR_in     = '0;
    bus.TBR_Clr    = 1'b0;
    #1 RESET = 1'b1;
    #2;
    check("rst_tbr", bus.TBR_out, 32'h0);
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_trap_req", 32'(bus.trap_req), 32'h0);
    check("rst_tt", 32'(bus.tt), 32'h0);
    check("rst_error", 32'(bus.error_mode), 32'h0);
    step();
    step();
    RESET = 1'b0;
    step();

    // 1: async reset in the middle of a request.
    bus.ET = 1'b1;
    bus.trap_src = 8'h05;
    step();
    bus.trap_src = 8'h00;
    exp_q.push_back(8'h01);
    step();
    check("t1_trap_req", 32'(bus.trap_req), 32'h1);
    check("t1_pending", 32'(bus.pending), 32'h05);
    @(negedge Clk);
    #1 RESET = 1'b1;
    #1;
    check("t1_rst_trap_req", 32'(bus.trap_req), 32'h0);
    check("t1_rst_tt", 32'(bus.tt), 32'h0);
    check("t1_rst_pending", 32'(bus.pending), 32'h0);
    check("t1_rst_tbr", bus.TBR_out, 32'h0);
    check("t1_rst_error", 32'(bus.error_mode), 32'h0);
    step();
    RESET = 1'b0;
    step();
    check("t1_idle_after", 32'(bus.trap_req), 32'h0);

    // 2: two-edge latency, priority and ack writes tt into TBR.
    bus.trap_src = 8'h0A;
    step();
    bus.trap_src = 8'h00;
    check("t2_no_req_1edge", 32'(bus.trap_req), 32'h0);
    exp_q.push_back(8'h02);
    step();
    check("t2_req_2edge", 32'(bus.trap_req), 32'h1);
    check("t2_tt", 32'(bus.tt), 32'h02);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("t2_tbr_tt", bus.TBR_out, 32'h0000_0020);
    check("t2_pending", 32'(bus.pending), 32'h08);
    check("t2_req_drop", 32'(bus.trap_req), 32'h0);
    exp_q.push_back(8'h04);
    step();
    check("t2_next_tt", 32'(bus.tt), 32'h04);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("t2_tbr_tt2", bus.TBR_out, 32'h0000_0040);
    check("t2_pending2", 32'(bus.pending), 32'h00);

    // 3: maskable source waits for ET.
    bus.ET = 1'b0;
    bus.trap_src = 8'h20;
    step();
    bus.trap_src = 8'h00;
    step();
    step();
    check("t3_no_req", 32'(bus.trap_req), 32'h0);
    check("t3_pending", 32'(bus.pending), 32'h20);
    check("t3_no_error", 32'(bus.error_mode), 32'h0);
    bus.ET = 1'b1;
    exp_q.push_back(8'h06);
    step();
    check("t3_req", 32'(bus.trap_req), 32'h1);
    check("t3_tt", 32'(bus.tt), 32'h06);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("t3_pending_clr", 32'(bus.pending), 32'h00);
    check("t3_tbr", bus.TBR_out, 32'h0000_0060);

    // 5: WRTBR together with ack, then clear priority, then plain WRTBR.
    bus.trap_src = 8'h04;
    step();
    bus.trap_src = 8'h00;
    exp_q.push_back(8'h03);
    step();
    bus.trap_ack   = 1'b1;
    bus.TBR_enable = 1'b1;
    bus.TBR_in     = 32'hFFFF_FFFF;
    step();
    bus.trap_ack = 1'b0;
    check("t5_wr_and_ack", bus.TBR_out, 32'hFFFF_F030);
    bus.TBR_Clr = 1'b1;
    step();
    bus.TBR_Clr = 1'b0;
    check("t5_clr_prio", bus.TBR_out, 32'h0);
    bus.TBR_in = 32'h1234_5ABC;
    step();
    bus.TBR_enable = 1'b0;
    check("t5_wrtbr", bus.TBR_out, 32'h1234_5000);

    // 6: no preemption, one IDLE cycle between back-to-back traps.
    bus.trap_src = 8'h08;
    step();
    bus.trap_src = 8'h00;
    exp_q.push_back(8'h04);
    step();
    bus.trap_src = 8'h01;
    step();
    bus.trap_src = 8'h00;
    step();
    check("t6_tt_frozen", 32'(bus.tt), 32'h04);
    check("t6_pending", 32'(bus.pending), 32'h09);
    exp_q.push_back(8'h01);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("t6_idle_gap", 32'(bus.trap_req), 32'h0);
    step();
    check("t6_req2", 32'(bus.trap_req), 32'h1);
    check("t6_tt2", 32'(bus.tt), 32'h01);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("t6_tbr", bus.TBR_out, 32'h1234_5010);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("t6_ack_idle_tbr", bus.TBR_out, 32'h1234_5010);

    // 4: non-maskable trap with ET=0 enters sticky error mode.
    bus.ET = 1'b0;
    bus.trap_src = 8'h02;
    step();
    bus.trap_src = 8'h00;
    step();
    check("t4_error", 32'(bus.error_mode), 32'h1);
    check("t4_no_req", 32'(bus.trap_req), 32'h0);
    bus.trap_ack = 1'b1;
    step();
    bus.trap_ack = 1'b0;
    check("t4_error_sticky", 32'(bus.error_mode), 32'h1);
    check("t4_ack_ignored", 32'(bus.pending), 32'h02);
    check("t4_tbr_kept", bus.TBR_out, 32'h1234_5010);
    bus.ET = 1'b1;
    bus.trap_src = 8'h08;
    step();
    bus.trap_src = 8'h00;
    step();
    check("t4_accumulate", 32'(bus.pending), 32'h0A);
    check("t4_still_no_req", 32'(bus.trap_req), 32'h0);
    RESET = 1'b1;
    #1;
    check("t4_rst_error", 32'(bus.error_mode), 32'h0);
    step();
    RESET = 1'b0;
    step();

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
